bcd_updown_chain: RTL and testbench

Parametrised multi-digit up/down counter: a chain of NUM_DIGITS cascaded 4-bit digits, each with its own modulus (2..10). It generalises the single-digit 0-9 stopwatch counter. It adds:
- per-digit modulus (mixed mod-10/mod-6 for mm:ss);
- synchronous load and clear;
- wrap or saturate mode;
- chain-level terminal flags and a registered wrap pulse.

It is the time-base core of the stopwatch display path and feeds the 7-segment decoders directly.

---
 rtl/bcd_updown_chain.sv | 79 +++++++
 tb/tb_bcd_updown_chain.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_chain.sv
// Multi-digit up/down counter built from cascaded per-digit modulus counters.
// Carries and borrows across the whole chain resolve in one cycle; carry_out is a registered wrap pulse.
module bcd_updown_chain #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter logic [31:0] DIGIT_MOD  = 32'h0000_6A6A,
  parameter bit          WRAP       = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    reverse,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    at_zero,
  output logic                    at_max,
  output logic                    carry_out
);

  logic [NUM_DIGITS-1:0][3:0] count_q, count_d;
  logic [NUM_DIGITS-1:0][3:0] digitTop;
  logic [NUM_DIGITS-1:0][3:0] loadNibble;
  logic                       carry_q, carry_d;
  logic [NUM_DIGITS:0]        lowerMax, lowerZero;
  logic                       wrapEvent;

  // lowerMax[i] / lowerZero[i] mean "every digit below i is at its top / at zero".
  always_comb begin
    lowerMax[0]  = 1'b1;
    lowerZero[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digitTop[i]     = DIGIT_MOD[4*i +: 4] - 4'd1;
      loadNibble[i]   = load_value[4*i +: 4];
      lowerMax[i+1]   = lowerMax[i] & (count_q[i] == digitTop[i]);
      lowerZero[i+1]  = lowerZero[i] & (count_q[i] == 4'd0);
    end
  end

  assign at_max    = lowerMax[NUM_DIGITS];
  assign at_zero   = lowerZero[NUM_DIGITS];
  assign wrapEvent = enable & (reverse ? at_zero : at_max);

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        count_d[i] = (loadNibble[i] > digitTop[i]) ? digitTop[i] : loadNibble[i];
      end
    end else if (enable && (WRAP || !wrapEvent)) begin
      // A full-chain wrap falls out of the per-digit rules; saturation simply skips the step.
      carry_d = wrapEvent;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!reverse && lowerMax[i]) begin
          count_d[i] = (count_q[i] == digitTop[i]) ? 4'd0 : count_q[i] + 4'd1;
        end else if (reverse && lowerZero[i]) begin
          count_d[i] = (count_q[i] == 4'd0) ? digitTop[i] : count_q[i] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign count     = count_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_bcd_updown_chain.sv
// Scoreboard bench for bcd_updown_chain: a wrapping (mm:ss) and a saturating instance.
// Stimulus pushes hand-computed expectations; a monitor drains and compares them on the falling edge.
module tb_bcd_updown_chain;

  logic        clk = 1'b0;
  logic        reset, enable, reverse, clear, load;
  logic [15:0] loadValue;
  logic [15:0] countW, countS;
  logic        atZeroW, atMaxW, carryW, atZeroS, atMaxS, carryS;
  logic        samplePulse = 1'b0;

  typedef struct {
    string       name;
    bit          sat;
    logic [15:0] count;
    logic        atZero;
    logic        atMax;
    logic        carry;
  } expect_t;

  expect_t sbq[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bcd_updown_chain #(.NUM_DIGITS(4), .DIGIT_MOD(32'h0000_6A6A), .WRAP(1'b1)) dutWrap (
    .clk(clk), .reset(reset), .enable(enable), .reverse(reverse), .clear(clear),
    .load(load), .load_value(loadValue), .count(countW), .at_zero(atZeroW),
    .at_max(atMaxW), .carry_out(carryW)
  );

  bcd_updown_chain #(.NUM_DIGITS(4), .DIGIT_MOD(32'h0000_6A6A), .WRAP(1'b0)) dutSat (
    .clk(clk), .reset(reset), .enable(enable), .reverse(reverse), .clear(clear),
    .load(load), .load_value(loadValue), .count(countS), .at_zero(atZeroS),
    .at_max(atMaxS), .carry_out(carryS)
  );

  task automatic checkOutput(input expect_t e);
    logic [15:0] c;
    logic        z, m, co;
    c  = e.sat ? countS  : countW;
    z  = e.sat ? atZeroS : atZeroW;
    m  = e.sat ? atMaxS  : atMaxW;
    co = e.sat ? carryS  : carryW;
    compared++;
    if (c !== e.count || z !== e.atZero || m !== e.atMax || co !== e.carry) begin
      mismatched++;
      $display("[TB] FAIL %s: got count=%h at_zero=%b at_max=%b carry=%b, want count=%h at_zero=%b at_max=%b carry=%b",
               e.name, c, z, m, co, e.count, e.atZero, e.atMax, e.carry);
    end
  endtask

  // The monitor drains everything queued so far, on the falling edge or on demand mid-cycle.
  always @(negedge clk or posedge samplePulse) begin
    while (sbq.size() > 0) checkOutput(sbq.pop_front());
  end

  task automatic expectState(input string name, input bit sat, input logic [15:0] c,
                             input logic z, input logic m, input logic co);
    expect_t e;
    e.name = name; e.sat = sat; e.count = c; e.atZero = z; e.atMax = m; e.carry = co;
    sbq.push_back(e);
  endtask

  task automatic driveInputs(input logic en, input logic rev, input logic clr,
                             input logic ld, input logic [15:0] lv);
    enable = en; reverse = rev; clear = clr; load = ld; loadValue = lv;
  endtask

  task automatic applyStimulus(input logic en, input logic rev, input logic clr,
                               input logic ld, input logic [15:0] lv);
    driveInputs(en, rev, clr, ld, lv);
    @(posedge clk);
    #1;
  endtask

  task automatic sampleNow();
    samplePulse = 1'b1;
    #1 samplePulse = 1'b0;
  endtask

  initial begin
    driveInputs(0, 0, 0, 0, 16'h0000);
    reset = 1'b1;
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    expectState("reset state", 0, 16'h0000, 1, 0, 0);
    reset = 1'b1;

    // Count up 60 seconds from zero.
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(1, 0, 0, 0, 16'h0000);
      if (k == 1)  expectState("up 1",  0, 16'h0001, 0, 0, 0);
      if (k == 10) expectState("up 10", 0, 16'h0010, 0, 0, 0);
      if (k == 59) expectState("up 59", 0, 16'h0059, 0, 0, 0);
      if (k == 60) expectState("up 60", 0, 16'h0100, 0, 0, 0);
    end

    // Up wrap from 59:59.
    applyStimulus(0, 0, 0, 1, 16'h5958);
    expectState("load 5958", 0, 16'h5958, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    expectState("up to max", 0, 16'h5959, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    expectState("up wrap", 0, 16'h0000, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 16'h0000);
    expectState("carry drops", 0, 16'h0000, 1, 0, 0);

    // Down at zero: saturating instance holds, wrapping instance rolls to max.
    applyStimulus(0, 1, 0, 1, 16'h0000);
    expectState("sat load 0", 1, 16'h0000, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    expectState("sat down 1", 1, 16'h0000, 1, 0, 0);
    expectState("wrap down", 0, 16'h5959, 0, 1, 1);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    expectState("sat down 2", 1, 16'h0000, 1, 0, 0);
    expectState("down after wrap", 0, 16'h5958, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    expectState("sat down 3", 1, 16'h0000, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 16'h5959);
    expectState("sat load max", 1, 16'h5959, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    expectState("sat up at max", 1, 16'h5959, 0, 1, 0);
    expectState("wrap up again", 0, 16'h0000, 1, 0, 1);

    // Borrow across three digits.
    applyStimulus(0, 1, 0, 1, 16'h1000);
    expectState("load 1000", 0, 16'h1000, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    expectState("borrow", 0, 16'h0959, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    expectState("down 0958", 0, 16'h0958, 0, 0, 0);

    // Priority and clamping.
    applyStimulus(0, 0, 0, 1, 16'h3412);
    expectState("load 3412", 0, 16'h3412, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 16'h1234);
    expectState("clear wins", 0, 16'h0000, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 16'hFFFF);
    expectState("clamp FFFF", 0, 16'h5959, 0, 1, 0);

    // Asynchronous reset mid-count, enable held across release.
    applyStimulus(0, 0, 0, 1, 16'h0123);
    expectState("load 0123", 0, 16'h0123, 0, 0, 0);
    driveInputs(1, 0, 0, 0, 16'h0000);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 expectState("async reset", 0, 16'h0000, 1, 0, 0);
    sampleNow();
    @(posedge clk);
    #1 expectState("held in reset", 0, 16'h0000, 1, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 expectState("first after release", 0, 16'h0001, 0, 0, 0);
    @(posedge clk);
    #1 expectState("second after release", 0, 16'h0002, 0, 0, 0);

    // Reset kills a pending carry pulse.
    applyStimulus(0, 0, 0, 1, 16'h5959);
    expectState("load max", 0, 16'h5959, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    expectState("wrap before reset", 0, 16'h0000, 1, 0, 1);
    driveInputs(0, 0, 0, 0, 16'h0000);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 expectState("reset kills carry", 0, 16'h0000, 1, 0, 0);
    sampleNow();
    @(posedge clk);
    #1 reset = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
